sram_burst_master: RTL

SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_burst_master_if.sv | 51 +++++
 rtl/sram_rd_skid.sv | 47 ++++
 rtl/sram_burst_master.sv | 99 +++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst master: FSM encoding and read-buffer sizing.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);
  localparam int SKID_PW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

endpackage

// File: rtl/sram_burst_master_if.sv
// Command, write-data, read-data, status and SRAM-side signals of the burst master.
interface sram_burst_master_if #(
  parameter int AW = 12,
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [MW-1:0] sram_wem;
  logic [DW-1:0] sram_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data, wr_mask,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output busy, done,
    output sram_cs, sram_we, sram_addr, sram_din, sram_wem,
    input  sram_dout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data, wr_mask,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  busy, done,
    input  sram_cs, sram_we, sram_addr, sram_din, sram_wem,
    output sram_dout
  );
endinterface

// File: rtl/sram_rd_skid.sv
// Small read-return FIFO: push/pop in the same cycle keeps occupancy; head is registered storage.
// Latency: a push is visible at the head the cycle after; pushes into a full FIFO without a pop are dropped.
module sram_rd_skid
  import sram_ctrl_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [DW-1:0]      head,
  output logic [SKID_CW-1:0] count
);

  logic [DW-1:0]      mem [SKID_DEPTH];
  logic [SKID_PW-1:0] wptr;
  logic [SKID_PW-1:0] rptr;
  logic               do_push;
  logic               do_pop;

  function automatic logic [SKID_PW-1:0] ptr_inc(input logic [SKID_PW-1:0] p);
    return (p == SKID_PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != SKID_CW'(SKID_DEPTH)) || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      count <= count + SKID_CW'(do_push) - SKID_CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_burst_master.sv
// Burst master turning one command into a run of single-cycle SRAM accesses with incrementing address.
// Writes issue in the wr_valid cycle; reads are throttled so the 2-entry return buffer can never overflow.
module sram_burst_master
  import sram_ctrl_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 64,
  parameter int MW = 8
) (
  input logic                 clk,
  input logic                 rst,
  sram_burst_master_if.master bus
);

  localparam int PW = SKID_CW + 1;

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      addr;
  logic [AW-1:0]      cnt;
  logic               inflight;
  logic               done_q;
  logic [SKID_CW-1:0] skid_cnt;
  logic [PW-1:0]      pending;
  logic               pop;
  logic               issue_wr;
  logic               issue_rd;
  logic               last_pop;
  logic               cmd_hs;

  assign cmd_hs   = (state == IDLE) && bus.cmd_valid;
  assign pop      = bus.rd_valid && bus.rd_ready;
  // Beats that will occupy the buffer once this cycle's pop and the returning read settle.
  assign pending  = PW'(skid_cnt) + PW'(inflight) - PW'(pop);
  assign issue_wr = (state == WRITE) && bus.wr_valid;
  assign issue_rd = (state == READ) && (pending < PW'(SKID_DEPTH));
  assign last_pop = (state == DRAIN) && pop && !inflight && (skid_cnt == SKID_CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : READ;
      WRITE:   if (issue_wr && cnt == '0) state_nxt = IDLE;
      READ:    if (issue_rd && cnt == '0) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= issue_rd;
      done_q   <= (issue_wr && cnt == '0) || last_pop;
      if (cmd_hs) begin
        addr <= bus.cmd_addr;
        cnt  <= bus.cmd_len;
      end else if (issue_wr || issue_rd) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.wr_ready  = (state == WRITE);
    bus.done      = done_q;
    bus.sram_cs   = issue_wr || issue_rd;
    bus.sram_we   = issue_wr;
    bus.sram_addr = addr;
    bus.sram_din  = issue_wr ? bus.wr_data : {DW{1'b0}};
    bus.sram_wem  = issue_wr ? bus.wr_mask : {MW{1'b0}};
  end

  // Read data returns the cycle after issue, which is exactly when inflight is set.
  sram_rd_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.sram_dout),
    .pop       (pop),
    .head      (bus.rd_data),
    .count     (skid_cnt)
  );

  assign bus.rd_valid = (skid_cnt != '0);

endmodule
